// File: rtl/led_share_pkg.sv
// rtl/led_share_pkg.sv - shared types and helpers for the LED share arbiter
//
// Purpose: FSM state enum, owner-index width helper and requester-count limits
// used by led_share_arbiter and rr_arbiter.
// Ports: none (package).
package led_share_pkg;

  localparam int LSA_MIN_NUM_REQ = 2;
  localparam int LSA_MAX_NUM_REQ = 16;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Width of an index into n requesters; never below one bit.
  function automatic int owner_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_share_arbiter_rr.sv
// rtl/led_share_arbiter_rr.sv - combinational round-robin arbiter
//
// Purpose: pick the first asserted request searching upward from a pointer,
// wrapping modulo N. The pointer register is owned by the parent.
// Ports:
//   i_req     [N]  request vector
//   i_ptr     [W]  highest-priority index (must be < N)
//   o_gnt     [N]  one-hot grant, zero when no request
//   o_gnt_idx [W]  index of the granted request
//   o_any     1    at least one request asserted
module rr_arbiter
  import led_share_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = owner_width(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_gnt_idx,
  output logic         o_any
);

  // Two passes give the wrap-around order: first indices at or above the
  // pointer, then those below it. The first hit wins.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!o_any && i_req[i] && (W'(i) >= i_ptr)) begin
        o_any     = 1'b1;
        o_gnt[i]  = 1'b1;
        o_gnt_idx = W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!o_any && i_req[i] && (W'(i) < i_ptr)) begin
        o_any     = 1'b1;
        o_gnt[i]  = 1'b1;
        o_gnt_idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/led_share_arbiter.sv
// rtl/led_share_arbiter.sv - time-multiplexes the LED bank between requesters
//
// Purpose: round-robin grant of the LED bank to one of NUM_REQ pattern
// requesters for a hold window of 2**HOLD_LOG2 cycles; idle display otherwise.
// Optional feature macro: LED_SHARE_IDLE_GRAY_EN (Gray-code idle display
// from a free-running counter; undefined = LEDs dark when idle).
// Ports:
//   i_clk          1               clock, rising edge
//   i_rst          1               synchronous active-high reset
//   i_req_valid    [NUM_REQ]       per-requester request
//   i_req_pattern  [NUM_REQ*LEDS]  pattern i at [i*LEDS +: LEDS]
//   o_req_ready    [NUM_REQ]       one-hot grant (combinational, ARB only)
//   o_led          [LEDS]          registered LED drive, active-high
//   o_busy         1               high while in HOLD
//   o_owner        [clog2 NUM_REQ] current or last owner index
module led_share_arbiter
  import led_share_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int LEDS      = 5,
  parameter  int HOLD_LOG2 = 22,
  localparam int OW        = owner_width(NUM_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  input  logic [NUM_REQ*LEDS-1:0] i_req_pattern,
  output logic [NUM_REQ-1:0]      o_req_ready,
  output logic [LEDS-1:0]         o_led,
  output logic                    o_busy,
  output logic [OW-1:0]           o_owner
);

  if ((NUM_REQ < LSA_MIN_NUM_REQ) || (NUM_REQ > LSA_MAX_NUM_REQ) || (HOLD_LOG2 < 1))
  begin : g_bad_cfg
    $error("led_share_arbiter: unsupported NUM_REQ or HOLD_LOG2");
  end

  state_t                r_state;
  state_t                w_next_state;
  logic [OW-1:0]         r_ptr;
  logic [OW-1:0]         r_owner;
  logic [LEDS-1:0]       r_led;
  logic                  r_busy;
  logic [HOLD_LOG2-1:0]  r_hold_cnt;

  logic [NUM_REQ-1:0]    w_gnt;
  logic [OW-1:0]         w_gnt_idx;
  logic                  w_any;
  logic                  w_grant;
  logic                  w_hold_done;
  logic [OW-1:0]         w_ptr_next;
  logic [LEDS-1:0]       w_win_pattern;
  logic [LEDS-1:0]       w_idle_led;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .i_req     (i_req_valid),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  // Counter all-ones marks the last cycle of the window.
  assign w_hold_done = (r_state == ST_HOLD) && (r_hold_cnt == '1);

  assign w_ptr_next = (w_gnt_idx == OW'(NUM_REQ - 1)) ? '0 : (w_gnt_idx + OW'(1));

  always_comb begin
    w_win_pattern = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_win_pattern = i_req_pattern[i*LEDS +: LEDS];
      end
    end
  end

`ifdef LED_SHARE_IDLE_GRAY_EN
  localparam int ICW = LEDS + HOLD_LOG2;

  logic [ICW-1:0]  r_idle_cnt;
  logic [LEDS-1:0] w_idle_top;

  // Free-running; grants do not clear it so the idle animation keeps phase.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + ICW'(1);
    end
  end

  assign w_idle_top = r_idle_cnt[ICW-1 -: LEDS];
  assign w_idle_led = w_idle_top ^ (w_idle_top >> 1);
`else
  assign w_idle_led = '0;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_ARB;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_ARB:  if (w_any)       w_next_state = ST_HOLD;
      ST_HOLD: if (w_hold_done) w_next_state = ST_ARB;
      default:                  w_next_state = ST_ARB;
    endcase
  end

  // Output logic: grants only in ARB and never while reset is asserted.
  always_comb begin
    o_req_ready = '0;
    w_grant     = 1'b0;
    if ((r_state == ST_ARB) && !i_rst) begin
      o_req_ready = w_gnt;
      w_grant     = w_any;
    end
  end

  // Registered LED / owner / busy datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr      <= '0;
      r_owner    <= '0;
      r_led      <= '0;
      r_busy     <= 1'b0;
      r_hold_cnt <= '0;
    end else if (w_grant) begin
      r_led      <= w_win_pattern;
      r_owner    <= w_gnt_idx;
      r_ptr      <= w_ptr_next;
      r_hold_cnt <= '0;
      r_busy     <= 1'b1;
    end else if (r_state == ST_HOLD) begin
      r_hold_cnt <= r_hold_cnt + HOLD_LOG2'(1);
      if (w_hold_done) begin
        r_busy <= 1'b0;
        r_led  <= w_idle_led;
      end
    end else begin
      r_led <= w_idle_led;
    end
  end

  assign o_led   = r_led;
  assign o_busy  = r_busy;
  assign o_owner = r_owner;

endmodule

// File: tb/tb_led_share_arbiter.sv
// tb/tb_led_share_arbiter.sv - scoreboard bench for led_share_arbiter
module tb_led_share_arbiter;

  localparam int NR = 4;
  localparam int LW = 5;
  localparam int HL = 2;
  localparam int HOLD_CYC = 1 << HL;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*LW-1:0] req_pattern;
  logic [NR-1:0]   req_ready;
  logic [LW-1:0]   led;
  logic            busy;
  logic [1:0]      owner;

  led_share_arbiter #(
    .NUM_REQ   (NR),
    .LEDS      (LW),
    .HOLD_LOG2 (HL)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .i_req_pattern (req_pattern),
    .o_req_ready   (req_ready),
    .o_led         (led),
    .o_busy        (busy),
    .o_owner       (owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [4:0]  pat;
  } exp_t;

  exp_t        exp_q[$];
  logic [4:0]  pats[NR];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  // Monitor state
  int          hold_left = 0;
  exp_t        cur;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx);
    exp_t e;
    e.idx = idx;
    e.pat = pats[idx];
    exp_q.push_back(e);
  endtask

  task automatic wait_grant(input string tag, input int budget);
    logic got;
    got = 1'b0;
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge clk);
      if (req_ready !== '0) got = 1'b1;
    end
    check(tag, 32'(got), 32'd1);
    tick();
  endtask

  task automatic settle(input int n);
    req_valid = '0;
    repeat (n) tick();
  endtask

  // Scoreboard monitor: pops one expectation per observed grant, then follows
  // the hold window (4 cycles of frozen pattern, then one idle cycle).
  always @(negedge clk) begin
    if (rst) begin
      hold_left = 0;
    end else begin
      if (hold_left > 1) begin
        check("hold_led",   32'(led),       32'(cur.pat));
        check("hold_busy",  32'(busy),      32'd1);
        check("hold_owner", 32'(owner),     32'(cur.idx));
        check("hold_ready", 32'(req_ready), 32'd0);
        hold_left--;
      end else if (hold_left == 1) begin
        check("post_busy", 32'(busy), 32'd0);
`ifndef LED_SHARE_IDLE_GRAY_EN
        check("post_led", 32'(led), 32'd0);
`endif
        hold_left = 0;
      end
      if (req_ready !== '0) begin
        check("ready_onehot", 32'($countones(req_ready)), 32'd1);
        check("ready_valid", 32'(req_ready & ~req_valid), 32'd0);
        if (exp_q.size() == 0) begin
          check("grant_expected", 32'(req_ready), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("grant_idx", 32'(req_ready), 32'(1 << cur.idx));
          hold_left = HOLD_CYC + 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    pats[0] = 5'b10001;
    pats[1] = 5'b01010;
    pats[2] = 5'b10101;
    pats[3] = 5'b11110;
    req_pattern = {pats[3], pats[2], pats[1], pats[0]};

    // Reset: all valid asserted, no grant while rst is high
    rst = 1'b1;
    req_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd0);
    end
    check("rst_led",   32'(led),   32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    tick();
    req_valid = '0;
    rst = 1'b0;

`ifdef LED_SHARE_IDLE_GRAY_EN
    // Idle Gray animation: top 5 bits of a 7-bit counter, Gray coded
    for (int j = 1; j <= 16; j++) begin
      logic [4:0] g;
      tick();
      g = 5'((j - 1) >> 2);
      check("gray_led", 32'(led), 32'(g ^ (g >> 1)));
    end
`endif

    // Single grant to requester 2
    push(2);
    req_valid = 4'b0100;
    wait_grant("single_grant", 8);
    req_valid = '0;
    settle(7);

    // Round-robin from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(0); push(1); push(2); push(3); push(0);
    req_valid = 4'hF;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant("rr_grant", 8);
      if (k > 0) check("rr_spacing", 32'(cyc - last), 32'(HOLD_CYC + 1));
      last = cyc;
    end
    settle(7);

    // Withdrawal: requester 1 pulses during requester 0's window
    push(0);
    req_valid = 4'b0001;
    wait_grant("wd_grant0", 8);
    req_valid = 4'b1010;
    tick();
    req_valid = 4'b1000;
    push(3);
    wait_grant("wd_grant3", 10);
    settle(7);

    // Reset in the second HOLD cycle aborts the window and clears the pointer
    push(0);
    req_valid = 4'b0001;
    wait_grant("mid_grant0", 8);
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_led",  32'(led),  32'd0);
    check("mid_owner", 32'(owner), 32'd0);
    req_valid = 4'b0011;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    push(0);
    push(1);
    wait_grant("after_rst_g0", 4);
    req_valid = 4'b0010;
    wait_grant("after_rst_g1", 8);
    settle(7);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
